// File: rtl/pipelined_fp_rounder.sv
// Two-stage floating-point rounder: stage 1 rounds the fraction, stage 2 folds the
// carry into the exponent and saturates on overflow. Define FP_ROUNDER_FLAGS_EN to add out_flags.
module pipelined_fp_rounder #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [2:0]        in_grs,
    input  logic [2:0]        in_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant
`ifdef FP_ROUNDER_FLAGS_EN
    ,
    output logic [1:0]        out_flags
`endif
);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              carry;
        logic [2:0]        rm;
`ifdef FP_ROUNDER_FLAGS_EN
        logic              inexact;
`endif
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } s2_t;

    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    logic [2:1] vld_pipe_q;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    logic       s1_adv, s2_adv;
    logic       round_up;
    logic [EXP_W-1:0] exp_rnd;
    logic       ovf, to_inf;

    assign s2_adv    = out_ready | ~vld_pipe_q[2];
    assign s1_adv    = ~vld_pipe_q[1] | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe_q[2];
    assign out_sign  = s2_q.sign;
    assign out_exp   = s2_q.exp;
    assign out_mant  = s2_q.mant;

    // Stage 1: round-increment decision and fraction add
    always_comb begin
        case (in_rm)
            RM_RNE:  round_up = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
            RM_RDN:  round_up = in_sign & (|in_grs);
            RM_RUP:  round_up = ~in_sign & (|in_grs);
            RM_RMM:  round_up = in_grs[2];
            default: round_up = 1'b0;
        endcase
        s1_d.sign = in_sign;
        s1_d.exp  = in_exp;
        s1_d.rm   = in_rm;
        {s1_d.carry, s1_d.mant} = {1'b0, in_mant} + {{MANT_W{1'b0}}, round_up};
`ifdef FP_ROUNDER_FLAGS_EN
        s1_d.inexact = |in_grs;
`endif
    end

    // Stage 2: carry into exponent; an all-ones exponent in or out means overflow
    always_comb begin
        exp_rnd = s1_q.carry ? s1_q.exp + EXP_ONE : s1_q.exp;
        ovf     = (&exp_rnd) | (&s1_q.exp);
        case (s1_q.rm)
            RM_RNE, RM_RMM: to_inf = 1'b1;
            RM_RDN:         to_inf = s1_q.sign;
            RM_RUP:         to_inf = ~s1_q.sign;
            default:        to_inf = 1'b0;
        endcase
        s2_d.sign = s1_q.sign;
        s2_d.exp  = exp_rnd;
        s2_d.mant = s1_q.carry ? '0 : s1_q.mant;
        if (ovf) begin
            s2_d.exp  = to_inf ? '1 : EXP_MAXF;
            s2_d.mant = to_inf ? '0 : '1;
        end
    end

`ifdef FP_ROUNDER_FLAGS_EN
    logic [1:0] flags_q;
    assign out_flags = flags_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
`ifdef FP_ROUNDER_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            if (s1_adv) vld_pipe_q[1] <= in_valid;
            if (s2_adv) vld_pipe_q[2] <= vld_pipe_q[1];
            if (in_valid && in_ready) s1_q <= s1_d;
            if (s2_adv && vld_pipe_q[1]) begin
                s2_q <= s2_d;
`ifdef FP_ROUNDER_FLAGS_EN
                flags_q <= {ovf, s1_q.inexact | ovf};
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_fp_rounder.sv
// Self-checking bench for pipelined_fp_rounder (MANT_W=23, EXP_W=8): directed corner
// vectors, backpressure, mid-flight reset and a randomized handshake run against a model.
module tb_pipelined_fp_rounder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic [2:0]  in_grs, in_rm;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
`ifdef FP_ROUNDER_FLAGS_EN
    logic [1:0]  out_flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_fp_rounder #(.MANT_W(23), .EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_grs(in_grs), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant)
`ifdef FP_ROUNDER_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        ovf;
        logic        inx;
    } res_t;

    // Reference: treat GRS as a remainder in eighths of an ulp and round arithmetically.
    function automatic res_t model(input logic sg, input logic [7:0] e, input logic [22:0] m,
                                   input logic [2:0] grs, input logic [2:0] rm);
        res_t r;
        int rem, mm, ee, up;
        bit ovf, inf;
        rem = int'(grs);
        mm  = int'(m);
        ee  = int'(e);
        case (rm)
            3'd0:    up = (rem > 4 || (rem == 4 && mm % 2 == 1)) ? 1 : 0;
            3'd2:    up = (sg && rem != 0) ? 1 : 0;
            3'd3:    up = (!sg && rem != 0) ? 1 : 0;
            3'd4:    up = (rem >= 4) ? 1 : 0;
            default: up = 0;
        endcase
        mm = mm + up;
        if (mm == (1 << 23)) begin
            mm = 0;
            ee = ee + 1;
        end
        ovf = (ee >= 255) || (int'(e) == 255);
        inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd2 && sg) || (rm == 3'd3 && !sg);
        if (ovf) begin
            ee = inf ? 255 : 254;
            mm = inf ? 0 : (1 << 23) - 1;
        end
        r.sign = sg;
        r.exp  = 8'(ee);
        r.mant = 23'(mm);
        r.ovf  = ovf;
        r.inx  = (rem != 0) || ovf;
        return r;
    endfunction

    // Drives one operand into an empty pipe with out_ready high and samples it one and two cycles later.
    task automatic send_one(input logic sg, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] g, input logic [2:0] rm,
                            output logic v1, output logic v2, output logic [31:0] dat,
                            output logic [1:0] fl);
        @(negedge clk);
        in_valid = 1'b1; in_sign = sg; in_exp = e; in_mant = m; in_grs = g; in_rm = rm;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 v1 = out_valid;
        @(negedge clk);
        #1 v2 = out_valid;
        dat = {out_sign, out_exp, out_mant};
`ifdef FP_ROUNDER_FLAGS_EN
        fl = out_flags;
`else
        fl = 2'b00;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_grs = '0; in_rm = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if ({out_sign, out_exp, out_mant} !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {out_sign, out_exp, out_mant});
        end
`ifdef FP_ROUNDER_FLAGS_EN
        checks++;
        if (out_flags !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", out_flags); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [7:0]  xexp;
        logic [22:0] xmant;
        logic        xovf;
        logic        xinx;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[17];
        logic v1, v2;
        logic [31:0] dat;
        logic [1:0] fl;
        tbl[0]  = '{1'b0, 8'h40, 23'h000001, 3'b100, 3'd0, 8'h40, 23'h000002, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h40, 23'h000002, 3'b100, 3'd0, 8'h40, 23'h000002, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b001, 3'd3, 8'h80, 23'h000000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 3'd4, 8'hFF, 23'h000000, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 3'd2, 8'hFE, 23'h7FFFFF, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'h40, 23'h123456, 3'b111, 3'd6, 8'h40, 23'h123456, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h00, 23'h7FFFFF, 3'b001, 3'd2, 8'h01, 23'h000000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'hFF, 23'h000000, 3'b000, 3'd1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b001, 3'd2, 8'hFF, 23'h000000, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b100, 3'd3, 8'hFE, 23'h7FFFFF, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b110, 3'd0, 8'hFF, 23'h000000, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'hFF, 23'h000005, 3'b000, 3'd3, 8'hFF, 23'h000000, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 8'hFF, 23'h000005, 3'b000, 3'd3, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h12, 23'h000003, 3'b011, 3'd0, 8'h12, 23'h000003, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h12, 23'h000003, 3'b000, 3'd0, 8'h12, 23'h000003, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'h12, 23'h000003, 3'b100, 3'd0, 8'h12, 23'h000004, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h12, 23'h000003, 3'b111, 3'd5, 8'h12, 23'h000003, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            send_one(tbl[i].sign, tbl[i].exp, tbl[i].mant, tbl[i].grs, tbl[i].rm, v1, v2, dat, fl);
            checks++;
            if ({v1, v2} !== 2'b01) begin
                errors++; $display("FAIL directed[%0d] latency valid@1,2 got %b want 01", i, {v1, v2});
            end
            checks++;
            if (dat !== {tbl[i].sign, tbl[i].xexp, tbl[i].xmant}) begin
                errors++;
                $display("FAIL directed[%0d] data got %h want %h", i, dat, {tbl[i].sign, tbl[i].xexp, tbl[i].xmant});
            end
`ifdef FP_ROUNDER_FLAGS_EN
            checks++;
            if (fl !== {tbl[i].xovf, tbl[i].xinx}) begin
                errors++; $display("FAIL directed[%0d] flags got %b want %b", i, fl, {tbl[i].xovf, tbl[i].xinx});
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic        sg[4];
        logic [7:0]  ex[4];
        logic [22:0] mt[4];
        logic [2:0]  gr[4], rmv[4];
        res_t q[$];
        res_t w;
        int acc, got, k;
        acc = 0; got = 0;
        for (int i = 0; i < 4; i++) begin
            sg[i] = 1'($urandom_range(0, 1));
            ex[i] = 8'($urandom_range(1, 250));
            mt[i] = 23'($urandom_range(0, 32'h7FFFFF));
            gr[i] = 3'($urandom_range(0, 7));
            rmv[i] = 3'($urandom_range(0, 4));
        end
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            k = (acc < 4) ? acc : 0;
            in_valid = (acc < 4);
            in_sign = sg[k]; in_exp = ex[k]; in_mant = mt[k]; in_grs = gr[k]; in_rm = rmv[k];
            out_ready = (cyc >= 5);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(in_sign, in_exp, in_mant, in_grs, in_rm));
                acc++;
            end
            if (out_valid && out_ready) begin
                w = q.pop_front();
                checks++;
                if ({out_sign, out_exp, out_mant} !== {w.sign, w.exp, w.mant}) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got %h want %h", got, {out_sign, out_exp, out_mant}, {w.sign, w.exp, w.mant});
                end
                got++;
            end
            if (cyc == 4) begin
                checks++;
                if (acc != 2 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_stall accepted %0d in_ready %b want 2 and 0", acc, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin errors++; $display("FAIL bp_drain got %0d results want 4", got); end
    endtask

    task automatic test_reset_mid();
        logic v1, v2;
        logic [31:0] dat;
        logic [1:0] fl;
        int extra;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h33; in_mant = 23'h0ABCDE; in_grs = 3'b101; in_rm = 3'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full out_valid %b in_ready %b want 1 0", out_valid, in_ready);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {out_sign, out_exp, out_mant} !== 32'h0) begin
            errors++; $display("FAIL rstmid_async out_valid %b data %h want 0 0", out_valid, {out_sign, out_exp, out_mant});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_release in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
        send_one(1'b0, 8'h55, 23'h000010, 3'b110, 3'd4, v1, v2, dat, fl);
        checks++;
        if ({v1, v2} !== 2'b01) begin
            errors++; $display("FAIL rstmid_latency valid@1,2 got %b want 01", {v1, v2});
        end
        checks++;
        if (dat !== {1'b0, 8'h55, 23'h000011}) begin
            errors++; $display("FAIL rstmid_data got %h want %h", dat, {1'b0, 8'h55, 23'h000011});
        end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 if (out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL rstmid_stale extra results %0d want 0", extra); end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t w;
        logic hold;
        logic [33:0] held;
        logic [33:0] cur;
        int sel;
        hold = 1'b0; held = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 380) && ($urandom_range(0, 9) < 7);
            in_sign = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            in_exp = (sel == 0) ? 8'($urandom_range(0, 255)) : (sel == 1) ? 8'hFE : (sel == 2) ? 8'hFF : 8'h00;
            in_mant = ($urandom_range(0, 1) == 1) ? 23'($urandom_range(0, 32'h7FFFFF))
                                                  : (($urandom_range(0, 1) == 1) ? 23'h7FFFFF : 23'h7FFFFE);
            in_grs = 3'($urandom_range(0, 7));
            in_rm = 3'($urandom_range(0, 7));
            out_ready = (cyc >= 380) || ($urandom_range(0, 9) < 6);
            #1;
`ifdef FP_ROUNDER_FLAGS_EN
            cur = {out_sign, out_exp, out_mant, out_flags};
`else
            cur = {out_sign, out_exp, out_mant, 2'b00};
`endif
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++; $display("FAIL rand_stable cyc %0d got %b/%h want 1/%h", cyc, out_valid, cur, held);
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_mant, in_grs, in_rm));
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc %0d got %h want no result", cyc, cur);
                end else begin
                    w = q.pop_front();
`ifdef FP_ROUNDER_FLAGS_EN
                    if (cur !== {w.sign, w.exp, w.mant, w.ovf, w.inx}) begin
                        errors++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, cur, {w.sign, w.exp, w.mant, w.ovf, w.inx});
                    end
`else
                    if (cur[33:2] !== {w.sign, w.exp, w.mant}) begin
                        errors++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, cur[33:2], {w.sign, w.exp, w.mant});
                    end
`endif
                end
            end
            hold = out_valid && !out_ready;
            held = cur;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_drain left %0d results want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
